// File: rtl/button_ctrl_pkg.sv
// Shared constants for the push-button event controller: register map,
// CTRL/STATUS bit positions and the event word layout.
package button_ctrl_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_CTRL    = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_EVENT   = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    localparam int CTRL_EVT_EN    = 0;
    localparam int STATUS_CNT_LSB = 0;
    localparam int STATUS_CNT_W   = 8;
    localparam int STATUS_OVF     = 15;

    localparam int EVT_PRESS_LSB   = 0;
    localparam int EVT_RELEASE_LSB = 16;
    localparam int EVT_VALID_BIT   = 31;

    // Event word: press mask low, release mask from bit 16, valid flag on top.
    function automatic logic [31:0] pack_event(input logic [14:0] press_mask,
                                               input logic [14:0] release_mask);
        logic [31:0] word;
        word = '0;
        word[EVT_PRESS_LSB   +: 15] = press_mask;
        word[EVT_RELEASE_LSB +: 15] = release_mask;
        word[EVT_VALID_BIT]         = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button event controller.
interface button_event_ctrl_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );

endinterface

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser, stability counter and debounced level,
// with single-cycle press/release pulses coincident with the level update.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin_lvl;
    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             settle;

    // Inverting by a constant before the synchroniser keeps it single-source
    // and lets every flop reset to 0 while still meaning "released".
    assign pin_lvl = pin ^ (ACTIVE_LOW != 0);

    assign settle = (sync_q[1] != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], pin_lvl};
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level         = level_q;
    assign press_pulse   = settle &  sync_q[1];
    assign release_pulse = settle & ~sync_q[1];

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced, interrupt-capable push-button controller on an Avalon-MM slave.
// Optional event FIFO built when BUTTON_EVENT_FIFO_EN is defined.
module button_event_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    button_event_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic             evt_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_clr;
    logic [WIDTH-1:0] edgecap_set;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_debounce (
                .clk           (clk),
                .reset_n       (reset_n),
                .pin           (in_port[gi]),
                .level         (level[gi]),
                .press_pulse   (press_pulse[gi]),
                .release_pulse (release_pulse[gi])
            );
        end
    endgenerate

    assign wr_en = bus.chipselect & bus.write;
    assign rd_en = bus.chipselect & bus.read;

    assign edgecap_clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign edgecap_set = evt_en ? press_pulse : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_en   <= 1'b0;
            irq_mask <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && bus.address == ADDR_CTRL)
                evt_en <= bus.writedata[CTRL_EVT_EN];
            if (wr_en && bus.address == ADDR_IRQMASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
            // A press landing on the same cycle as its clear must not be lost.
            edgecap <= (edgecap & ~edgecap_clr) | edgecap_set;
            irq     <= |(edgecap & irq_mask);
        end
    end

`ifdef BUTTON_EVENT_FIFO_EN
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push_req;
    logic           push;
    logic           pop;
    logic           ovf_set;
    logic           overflow;
    logic [31:0]    evt_word;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_L);

    assign push_req = evt_en && (|(press_pulse | release_pulse));
    assign pop      = rd_en && (bus.address == ADDR_EVENT) && !fifo_empty;
    // A same-cycle pop frees the slot the push needs, even when full.
    assign push     = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && fifo_full && !pop;
    assign evt_word = pack_event(15'(press_pulse), 15'(release_pulse));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (ovf_set)
                overflow <= 1'b1;
            else if (wr_en && bus.address == ADDR_STATUS)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= evt_word;
    end
`else
    logic unused_fifo;
    assign unused_fifo = ^{release_pulse, 1'(FIFO_DEPTH)};
`endif

    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];

    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_DATA:    rd_data[WIDTH-1:0]  = level;
            ADDR_CTRL:    rd_data[CTRL_EVT_EN] = evt_en;
            ADDR_IRQMASK: rd_data[WIDTH-1:0]  = irq_mask;
            ADDR_EDGECAP: rd_data[WIDTH-1:0]  = edgecap;
`ifdef BUTTON_EVENT_FIFO_EN
            ADDR_EVENT:   rd_data = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
            ADDR_STATUS: begin
                rd_data[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(fifo_count);
                rd_data[STATUS_OVF]                     = overflow;
            end
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_en ? rd_data : '0;
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl (DEBOUNCE_CYCLES=16, active-low pins).
module tb_button_event_ctrl;
    import button_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] in_port = 2'b11;
    logic       irq;
    logic [31:0] rd;
    int errors = 0;
    int checks = 0;

    button_event_ctrl_if bus();

    button_event_ctrl #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (16),
        .ACTIVE_LOW      (1),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Consumes n rising edges, returns on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        tick(1);
        d              = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fifo_pat [4];
        fifo_pat[0] = 32'h8000_0001;
        fifo_pat[1] = 32'h8000_0002;
        fifo_pat[2] = 32'h8001_0000;
        fifo_pat[3] = 32'h8002_0000;

        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(2);
        bus_read(ADDR_DATA, rd);    check("data_after_rst", rd, 32'h0);
        bus_read(ADDR_IRQMASK, rd); check("mask_after_rst", rd, 32'h0);

        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_IRQMASK, 32'h1);
        bus_read(ADDR_CTRL, rd);    check("ctrl_rb", rd, 32'h1);
        bus_read(ADDR_IRQMASK, rd); check("mask_rb", rd, 32'h1);

        // Short glitch on button 1 must not register.
        in_port[1] = 1'b0; tick(10);
        in_port[1] = 1'b1; tick(30);
        bus_read(ADDR_DATA, rd);    check("glitch_data", rd, 32'h0);
        bus_read(ADDR_EDGECAP, rd); check("glitch_edgecap", rd, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Clean press on button 0: edgecap sets at edge 18, irq at edge 19.
        in_port[0] = 1'b0;
        tick(17);
        check("press_irq_e17", {31'b0, irq}, 32'h0);
        bus_read(ADDR_EDGECAP, rd); check("press_edgecap_e18", rd, 32'h0);
        check("press_irq_e18", {31'b0, irq}, 32'h0);
        bus_read(ADDR_EDGECAP, rd); check("press_edgecap_e19", rd, 32'h1);
        check("press_irq_e19", {31'b0, irq}, 32'h1);
        bus_read(ADDR_DATA, rd);    check("press_data", rd, 32'h1);
        tick(20);

        // Clear colliding with a new press: the set wins.
        in_port[0] = 1'b1; tick(30);
        bus_write(ADDR_EDGECAP, 32'h1);
        tick(2);
        check("clr_irq", {31'b0, irq}, 32'h0);
        bus_read(ADDR_EDGECAP, rd); check("clr_edgecap", rd, 32'h0);
        in_port[0] = 1'b0;
        tick(17);
        bus_write(ADDR_EDGECAP, 32'h1);
        bus_read(ADDR_EDGECAP, rd); check("collide_edgecap", rd, 32'h1);
        check("collide_irq", {31'b0, irq}, 32'h1);
        bus_write(ADDR_EDGECAP, 32'h1);
        check("clr2_irq_same", {31'b0, irq}, 32'h1);
        tick(1);
        check("clr2_irq_fall", {31'b0, irq}, 32'h0);
        bus_read(ADDR_EDGECAP, rd); check("clr2_edgecap", rd, 32'h0);

        // EVT_EN=0: level still tracks, no capture, no event.
        in_port[0] = 1'b1; tick(30);
        bus_write(ADDR_EDGECAP, 32'h1);
        bus_write(ADDR_CTRL, 32'h0);
        in_port[0] = 1'b0; tick(30);
        bus_read(ADDR_DATA, rd);    check("dis_data", rd, 32'h1);
        bus_read(ADDR_EDGECAP, rd); check("dis_edgecap", rd, 32'h0);
        check("dis_irq", {31'b0, irq}, 32'h0);

`ifdef BUTTON_EVENT_FIFO_EN
        // Four events so far: press0, release0, press0, release0.
        bus_read(ADDR_STATUS, rd); check("dis_status", rd, 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            bus_read(ADDR_EVENT, rd);
            check($sformatf("early_evt%0d", i), rd, (i % 2 == 0) ? 32'h8000_0001 : 32'h8001_0000);
        end
        bus_read(ADDR_EVENT, rd);  check("early_empty", rd, 32'h0);
        in_port[0] = 1'b1; tick(30);
        bus_read(ADDR_STATUS, rd); check("dis_release_status", rd, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);

        for (int r = 0; r < 5; r++) begin
            in_port[0] = 1'b0; tick(25);
            in_port[1] = 1'b0; tick(25);
            in_port[0] = 1'b1; tick(25);
            in_port[1] = 1'b1; tick(25);
        end
        bus_read(ADDR_STATUS, rd); check("ovf_status", rd, 32'h0000_8008);
        for (int i = 0; i < 8; i++) begin
            bus_read(ADDR_EVENT, rd);
            check($sformatf("fifo_evt%0d", i), rd, fifo_pat[i % 4]);
        end
        bus_read(ADDR_EVENT, rd);  check("fifo_empty_rd", rd, 32'h0);
        bus_read(ADDR_STATUS, rd); check("ovf_sticky", rd, 32'h0000_8000);
        bus_write(ADDR_STATUS, 32'h0);
        bus_read(ADDR_STATUS, rd); check("status_cleared", rd, 32'h0);
`else
        in_port[0] = 1'b1; tick(30);
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_EVENT, rd);  check("nofifo_event", rd, 32'h0);
        bus_read(ADDR_STATUS, rd); check("nofifo_status", rd, 32'h0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd);        check("unused_addr", rd, 32'h0);
        bus_read(ADDR_DATA, rd);   check("release_data", rd, 32'h0);
`endif

        // Reset mid-debounce (counter at 10), then held button reports after 18 edges.
        bus_write(ADDR_IRQMASK, 32'h3);
        bus_write(ADDR_EDGECAP, 32'h3);
        in_port[0] = 1'b0; tick(25);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        in_port[1] = 1'b0;
        tick(12);
        reset_n = 1'b0;
        #1;
        check("mid_rst_readdata", bus.readdata, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        in_port[0] = 1'b1;
        tick(3);
        reset_n = 1'b1;
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_IRQMASK, 32'h2);
        tick(15);
        bus_read(ADDR_DATA, rd);    check("held_data_e18", rd, 32'h0);
        check("held_irq_e18", {31'b0, irq}, 32'h0);
        bus_read(ADDR_DATA, rd);    check("held_data_e19", rd, 32'h2);
        check("held_irq_e19", {31'b0, irq}, 32'h1);
        bus_read(ADDR_EDGECAP, rd); check("held_edgecap", rd, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
